// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 pooling engine (max or floor-average) for raster-scan feature maps.
// Top-row pair results are parked in a half-width line buffer until the matching bottom row arrives.
module max_pool_stream #(
    parameter int DATA_SIZE = 16,
    parameter int CHANNELS  = 6,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int POOL_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*DATA_SIZE-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*DATA_SIZE-1:0] out_data,
    output logic                          out_last
);

    // Partial sums need one guard bit; the final four-sample sum needs two.
    localparam int PW       = DATA_SIZE + 1;
    localparam int SW       = DATA_SIZE + 2;
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam bit AVG_MODE = (POOL_MODE == 32'sd1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]             col_r;
    logic [ROW_W-1:0]             row_r;
    logic [CHANNELS*DATA_SIZE-1:0] left_r;
    logic [CHANNELS*PW-1:0]       linebuf_r [LB_DEPTH];
    logic                         out_valid_r;
    logic [CHANNELS*DATA_SIZE-1:0] out_data_r;
    logic                         out_last_r;

    logic                         in_ready_s;
    logic                         accept_s;
    logic                         load_s;
    logic                         store_s;
    logic                         last_s;
    logic [LB_AW-1:0]             lb_idx_s;
    logic [CHANNELS*PW-1:0]       lb_rd_s;
    logic [CHANNELS*PW-1:0]       pair_s;
    logic [CHANNELS*DATA_SIZE-1:0] result_s;

    // Horizontal combine of two raw samples; result carries a guard bit.
    function automatic logic [PW-1:0] pair_combine(input logic [DATA_SIZE-1:0] a,
                                                   input logic [DATA_SIZE-1:0] b);
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        logic [PW-1:0] res;
        ax = {a[DATA_SIZE-1], a};
        bx = {b[DATA_SIZE-1], b};
        if (AVG_MODE) begin
            res = ax + bx;
        end else if ($signed(bx) > $signed(ax)) begin
            res = bx;
        end else begin
            res = ax;
        end
        return res;
    endfunction

    // Vertical combine of the upper (buffered) and lower pair; average floors via the shift.
    function automatic logic [DATA_SIZE-1:0] final_combine(input logic [PW-1:0] up,
                                                           input logic [PW-1:0] low);
        logic [SW-1:0]        ux;
        logic [SW-1:0]        lx;
        logic [SW-1:0]        sum_v;
        logic [DATA_SIZE-1:0] res;
        ux    = {up[PW-1], up};
        lx    = {low[PW-1], low};
        sum_v = ux + lx;
        if (AVG_MODE) begin
            res = DATA_SIZE'(sum_v >> 2'd2);
        end else if ($signed(lx) > $signed(ux)) begin
            res = DATA_SIZE'(lx);
        end else begin
            res = DATA_SIZE'(ux);
        end
        return res;
    endfunction

    // Handshake decode, line-buffer addressing and per-channel datapath.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        load_s     = 1'b0;
        store_s    = 1'b0;
        last_s     = 1'b0;
        lb_idx_s   = '0;
        lb_rd_s    = '0;
        pair_s     = '0;
        result_s   = '0;

        in_ready_s = rst_n && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
        store_s    = accept_s && col_r[0] && !row_r[0];
        load_s     = accept_s && col_r[0] && row_r[0];
        last_s     = (row_r == ROW_LAST) && (col_r == COL_LAST);
        lb_idx_s   = LB_AW'(col_r >> 1'b1);
        lb_rd_s    = linebuf_r[lb_idx_s];
        for (int c = 0; c < CHANNELS; c++) begin
            pair_s[c*PW +: PW] = pair_combine(left_r[c*DATA_SIZE +: DATA_SIZE],
                                              in_data[c*DATA_SIZE +: DATA_SIZE]);
            result_s[c*DATA_SIZE +: DATA_SIZE] = final_combine(lb_rd_s[c*PW +: PW],
                                                               pair_s[c*PW +: PW]);
        end
    end

    // Raster position: col wraps into row, row wraps at the frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Left pixel of the current horizontal pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_r <= '0;
        end else if (accept_s && !col_r[0]) begin
            left_r <= in_data;
        end else begin
            left_r <= left_r;
        end
    end

    // Top-row pair results; contents are meaningless until rewritten, so no reset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            linebuf_r[lb_idx_s] <= pair_s;
        end
    end

    // Single-entry output register; a load in the same cycle as a pop wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_last_r  <= last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_last_r  <= out_last_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_last_r  <= out_last_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_max_pool_stream.sv
// Randomized self-checking bench: four pooling instances (max/avg, several geometries)
// checked against a window-level reference model and a per-instance scoreboard.
module tb_max_pool_stream;

    localparam int NI   = 4;
    localparam int MAXW = 96;

    logic clk = 1'b0;
    logic rst_n;
    logic             in_valid_a  [NI];
    logic             in_ready_a  [NI];
    logic [MAXW-1:0]  in_data_a   [NI];
    logic             out_valid_a [NI];
    logic             out_ready_a [NI];
    logic [MAXW-1:0]  out_data_a  [NI];
    logic             out_last_a  [NI];
    logic [15:0]      od0;
    logic [15:0]      od1;
    logic [95:0]      od2;
    logic [31:0]      od3;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [MAXW:0]    exp_q [NI][$];
    int               pops  [NI];
    int               lasts [NI];
    logic [MAXW-1:0]  frame_buf [784];
    bit               rand_ready  [NI];
    bit               fixed_ready [NI];
    bit               gaps        [NI];
    logic             prev_hold   [NI];
    logic [MAXW:0]    prev_out    [NI];
    bit               bp_done;

    always #5 clk = ~clk;

    max_pool_stream #(.DATA_SIZE(16), .CHANNELS(1), .IMG_W(4), .IMG_H(4), .POOL_MODE(0)) u_max4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_data(in_data_a[0][15:0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_data(od0), .out_last(out_last_a[0]));
    max_pool_stream #(.DATA_SIZE(16), .CHANNELS(1), .IMG_W(4), .IMG_H(4), .POOL_MODE(1)) u_avg4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_data(in_data_a[1][15:0]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_data(od1), .out_last(out_last_a[1]));
    max_pool_stream #(.DATA_SIZE(16), .CHANNELS(6), .IMG_W(28), .IMG_H(28), .POOL_MODE(0)) u_max28 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .in_data(in_data_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .out_data(od2), .out_last(out_last_a[2]));
    max_pool_stream #(.DATA_SIZE(16), .CHANNELS(2), .IMG_W(6), .IMG_H(4), .POOL_MODE(1)) u_avg6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
        .in_data(in_data_a[3][31:0]), .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]),
        .out_data(od3), .out_last(out_last_a[3]));

    assign out_data_a[0] = {80'd0, od0};
    assign out_data_a[1] = {80'd0, od1};
    assign out_data_a[2] = od2;
    assign out_data_a[3] = {64'd0, od3};

    function automatic int cfg_w(int k);
        case (k)
            2:       return 28;
            3:       return 6;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_h(int k);
        return (k == 2) ? 28 : 4;
    endfunction

    function automatic int cfg_ch(int k);
        case (k)
            2:       return 6;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit cfg_avg(int k);
        return (k == 1) || (k == 3);
    endfunction

    function automatic logic [MAXW-1:0] ch_mask(int k);
        logic [MAXW-1:0] m;
        m = '0;
        for (int c = 0; c < cfg_ch(k); c++) m[c*16 +: 16] = 16'hFFFF;
        return m;
    endfunction

    function automatic int sample(int idx, int c);
        logic [15:0] v;
        v = frame_buf[idx][c*16 +: 16];
        return int'($signed(v));
    endfunction

    task automatic check_eq(string tag, logic [127:0] obs, logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: every 2x2 window whose bottom-right pixel lies within the first n beats.
    task automatic model_frame(int k, int n);
        int w, h, s[4], r;
        logic [MAXW-1:0] d;
        logic lst;
        w = cfg_w(k);
        h = cfg_h(k);
        for (int wy = 0; wy < h / 2; wy++) begin
            for (int wx = 0; wx < w / 2; wx++) begin
                if ((2 * wy + 1) * w + 2 * wx + 1 < n) begin
                    d = '0;
                    for (int c = 0; c < cfg_ch(k); c++) begin
                        s[0] = sample(2 * wy * w + 2 * wx, c);
                        s[1] = sample(2 * wy * w + 2 * wx + 1, c);
                        s[2] = sample((2 * wy + 1) * w + 2 * wx, c);
                        s[3] = sample((2 * wy + 1) * w + 2 * wx + 1, c);
                        if (cfg_avg(k)) begin
                            r = s[0] + s[1] + s[2] + s[3];
                            r = (r >= 0) ? r / 4 : -((-r + 3) / 4);
                        end else begin
                            r = s[0];
                            for (int j = 1; j < 4; j++) if (s[j] > r) r = s[j];
                        end
                        d[c*16 +: 16] = 16'(r);
                    end
                    lst = (wy == h / 2 - 1) && (wx == w / 2 - 1);
                    exp_q[k].push_back({lst, d});
                end
            end
        end
    endtask

    task automatic push(int k, logic [MAXW-1:0] d);
        int n;
        bit acc;
        if (gaps[k]) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = d;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready_a[k];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid_a[k] = 1'b0;
        check_eq($sformatf("accept[%0d]", k), acc, 1'b1);
    endtask

    task automatic send(int k, int n);
        model_frame(k, n);
        for (int i = 0; i < n; i++) push(k, frame_buf[i]);
    endtask

    task automatic fill_random(int k, bit extreme);
        logic [MAXW-1:0] v;
        for (int i = 0; i < cfg_w(k) * cfg_h(k); i++) begin
            v = {$urandom, $urandom, $urandom};
            if (extreme) begin
                for (int c = 0; c < 6; c++) v[c*16 +: 16] = v[c*16] ? 16'h7FFF : 16'h8000;
            end
            frame_buf[i] = v & ch_mask(k);
        end
    endtask

    task automatic put_win(int k, int wx, int wy, logic [15:0] a, logic [15:0] b,
                           logic [15:0] c, logic [15:0] d);
        int w;
        w = cfg_w(k);
        frame_buf[2 * wy * w + 2 * wx]           = {80'd0, a};
        frame_buf[2 * wy * w + 2 * wx + 1]       = {80'd0, b};
        frame_buf[(2 * wy + 1) * w + 2 * wx]     = {80'd0, c};
        frame_buf[(2 * wy + 1) * w + 2 * wx + 1] = {80'd0, d};
    endtask

    task automatic drain(int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq($sformatf("drain[%0d]", k), exp_q[k].size(), 0);
    endtask

    // Downstream ready: either randomized or a fixed level chosen by the test.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NI; k++) begin
            out_ready_a[k] = rand_ready[k] ? ($urandom_range(0, 3) != 0) : fixed_ready[k];
        end
    end

    // Scoreboard plus hold-stability check on every stalled output.
    always @(negedge clk) begin
        logic [MAXW:0] e;
        for (int k = 0; k < NI; k++) begin
            if (prev_hold[k]) begin
                check_eq($sformatf("hold_valid[%0d]", k), out_valid_a[k], 1'b1);
                check_eq($sformatf("hold_data[%0d]", k), {out_last_a[k], out_data_a[k]}, prev_out[k]);
            end
            if (rst_n && out_valid_a[k] && out_ready_a[k]) begin
                if (exp_q[k].size() == 0) begin
                    check_eq($sformatf("unexpected_out[%0d]", k), out_valid_a[k], 1'b0);
                end else begin
                    e = exp_q[k].pop_front();
                    check_eq($sformatf("out_data[%0d]", k), out_data_a[k], e[MAXW-1:0]);
                    check_eq($sformatf("out_last[%0d]", k), out_last_a[k], e[MAXW]);
                    pops[k] = pops[k] + 1;
                    if (e[MAXW]) lasts[k] = lasts[k] + 1;
                end
            end
            prev_hold[k] <= rst_n && out_valid_a[k] && !out_ready_a[k];
            prev_out[k]  <= {out_last_a[k], out_data_a[k]};
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bp_done = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid_a[k] = 1'b0;
            in_data_a[k]  = '0;
            rand_ready[k] = 1'b0;
            fixed_ready[k] = 1'b1;
            gaps[k] = 1'b0;
            pops[k] = 0;
            lasts[k] = 0;
            prev_hold[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("rst_valid[%0d]", k), out_valid_a[k], 1'b0);
            check_eq($sformatf("rst_ready[%0d]", k), in_ready_a[k], 1'b0);
            check_eq($sformatf("rst_last[%0d]", k), out_last_a[k], 1'b0);
            check_eq($sformatf("rst_data[%0d]", k), out_data_a[k], 96'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic max 4x4 with ramp 0..15 and exact output latency.
        for (int i = 0; i < 16; i++) frame_buf[i] = MAXW'(i);
        model_frame(0, 16);
        for (int i = 0; i < 16; i++) begin
            push(0, frame_buf[i]);
            check_eq($sformatf("latency_px%0d", i), out_valid_a[0],
                     (i == 5) || (i == 7) || (i == 13) || (i == 15));
        end
        drain(0);

        // Signed max windows.
        fill_random(0, 1'b0);
        put_win(0, 0, 0, 16'hFFFD, 16'hFFFF, 16'h8000, 16'hFFFE);
        put_win(0, 1, 0, 16'hFFFF, 16'h0002, 16'hFFFB, 16'h0001);
        put_win(0, 0, 1, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        send(0, 16);
        drain(0);

        // Average windows incl. floor on negatives and both rails.
        fill_random(1, 1'b0);
        put_win(1, 0, 0, 16'd1, 16'd2, 16'd3, 16'd5);
        put_win(1, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        put_win(1, 0, 1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        put_win(1, 1, 1, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        send(1, 16);
        drain(1);
        rand_ready[1] = 1'b1;
        gaps[1] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill_random(1, f[0]);
            send(1, 16);
        end
        drain(1);

        // Backpressure: stall after the first output, then release.
        fixed_ready[0] = 1'b0;
        @(posedge clk);
        #3;
        for (int i = 0; i < 16; i++) frame_buf[i] = MAXW'(i);
        fork
            begin
                send(0, 16);
                bp_done = 1'b1;
            end
        join_none
        n = 0;
        while (!out_valid_a[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_first_valid", out_valid_a[0], 1'b1);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready_a[0], 1'b0);
            check_eq("bp_out_data", out_data_a[0], 96'd5);
        end
        fixed_ready[0] = 1'b1;
        n = 0;
        while (!bp_done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("bp_done", bp_done, 1'b1);
        drain(0);

        // Two back-to-back 28x28 six-channel frames with gaps and random ready.
        rand_ready[2] = 1'b1;
        gaps[2] = 1'b1;
        for (int f = 0; f < 2; f++) begin
            fill_random(2, 1'b0);
            send(2, 784);
        end
        drain(2);
        check_eq("frame_out_count", pops[2], 392);
        check_eq("frame_last_count", lasts[2], 2);

        // Non-square average instance, random and rail-heavy data.
        rand_ready[3] = 1'b1;
        gaps[3] = 1'b1;
        for (int f = 0; f < 4; f++) begin
            fill_random(3, f[0]);
            send(3, 24);
        end
        drain(3);
        check_eq("avg6_out_count", pops[3], 24);

        // Reset after 9 beats, then a fresh frame must be clean.
        fill_random(0, 1'b0);
        send(0, 9);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_in_ready", in_ready_a[0], 1'b0);
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", out_valid_a[0], 1'b0);
        check_eq("mid_rst_last", out_last_a[0], 1'b0);
        rst_n = 1'b1;
        check_eq("mid_rst_queue", exp_q[0].size(), 0);
        fill_random(0, 1'b0);
        send(0, 16);
        drain(0);

        // Random max frames with backpressure and gaps.
        rand_ready[0] = 1'b1;
        gaps[0] = 1'b1;
        for (int f = 0; f < 4; f++) begin
            fill_random(0, f[0]);
            send(0, 16);
        end
        drain(0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
